// File: rtl/gate_vector_stepper.sv
// gate_vector_stepper: sweeps all gate input vectors, samples X after each dwell and scores it against EXP_TABLE (GATE_VECTOR_STEPPER_FAILVEC_EN adds first-fail capture)
module gate_vector_stepper #(
  parameter int N_IN = 2,
  parameter int DWELL = 100,
  parameter logic [2**N_IN-1:0] EXP_TABLE = 4'b1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_x,
  output logic            busy,
  output logic            sample_stb,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_vec
);
  localparam int CW = $clog2(DWELL + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] dwell_cnt;
  logic last_dwell, last_vec, mism, accept, sample;
  assign last_dwell = dwell_cnt == CW'(DWELL - 1);
  assign last_vec = vec_out == {N_IN{1'b1}};
  assign mism = dut_x != EXP_TABLE[vec_out];
  assign accept = state == IDLE && start;
  assign sample = state == DRIVE && last_dwell;
  assign busy = state == DRIVE;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = DRIVE;
    else if (sample && last_vec) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec_out <= '0;
      dwell_cnt <= '0;
      sample_stb <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_nx;
      sample_stb <= sample;
      done <= state == DONE;
      if (accept) begin
        vec_out <= '0;
        dwell_cnt <= '0;
        err_cnt <= '0;
        pass <= 1'b0;
      end
      if (busy) dwell_cnt <= last_dwell ? '0 : dwell_cnt + 1'b1;
      if (sample && mism) err_cnt <= err_cnt + 1'b1;
      if (sample && !last_vec) vec_out <= vec_out + 1'b1;
      if (state == DONE) pass <= err_cnt == '0;
    end
  end
`ifdef GATE_VECTOR_STEPPER_FAILVEC_EN
  logic [N_IN-1:0] fail_q;
  // err_cnt still zero marks the first mismatch of the run
  always_ff @(posedge clk) begin
    if (rst || accept) fail_q <= '0;
    else if (sample && mism && err_cnt == '0) fail_q <= vec_out;
  end
  assign fail_vec = fail_q;
`else
  assign fail_vec = '0;
`endif
endmodule

// File: tb/tb_gate_vector_stepper.sv
// tb_gate_vector_stepper: directed checks of the AND sweep (DWELL=4) and an OR sweep (DWELL=1)
module tb_gate_vector_stepper;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  int mode = 0;
  logic [1:0] vec, vec2, fail_vec, fail_vec2;
  logic [2:0] err_cnt, err_cnt2;
  logic busy, sample_stb, done, pass, busy2, sample_stb2, done2, pass2, x, x2;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  assign x = mode == 0 ? &vec : mode == 2;
  assign x2 = |vec2;
  gate_vector_stepper #(.N_IN(2), .DWELL(4), .EXP_TABLE(4'b1000)) u_dut (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec), .dut_x(x), .busy(busy),
    .sample_stb(sample_stb), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_vec(fail_vec));
  gate_vector_stepper #(.N_IN(2), .DWELL(1), .EXP_TABLE(4'b1110)) u_or (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec2), .dut_x(x2), .busy(busy2),
    .sample_stb(sample_stb2), .done(done2), .pass(pass2), .err_cnt(err_cnt2), .fail_vec(fail_vec2));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask
  // pulses start, returns the cycle (after the accepting edge) done rose, stb count, vec at 1,5,9,13
  task automatic run(input int restart_at, output int dn, output int stb, output logic [7:0] vs);
    dn = 0; stb = 0; vs = '0;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    for (int n = 1; n <= 40 && dn == 0; n++) begin
      @(posedge clk) #1;
      if (n == 1) vs[1:0] = vec;
      if (n == 5) vs[3:2] = vec;
      if (n == 9) vs[5:4] = vec;
      if (n == 13) vs[7:6] = vec;
      if (n == restart_at) start = 1'b1;
      if (n == restart_at + 1) start = 1'b0;
      stb += int'(sample_stb);
      if (done) dn = n;
    end
  endtask
  int dn, stb;
  logic [7:0] vs;
  logic [1:0] fv_exp;
  initial begin
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vec", vec, 0); check("rst_busy", busy, 0); check("rst_stb", sample_stb, 0);
    check("rst_done", done, 0); check("rst_pass", pass, 0); check("rst_err", err_cnt, 0);
    check("rst_fail", fail_vec, 0);
    @(negedge clk) begin rst = 1'b0; start = 1'b0; end
    repeat (2) @(posedge clk);
    #1 check("idle_busy", busy, 0);
    mode = 0;
    run(0, dn, stb, vs);
    check("and_done_t", dn, 17); check("and_stb", stb, 4); check("and_vecs", vs, 8'b11_10_01_00);
    check("and_pass", pass, 1); check("and_err", err_cnt, 0); check("and_busy_done", busy, 0);
    check("and_vec_hold", vec, 3);
    repeat (3) @(posedge clk);
    #1 check("pass_held", pass, 1);
`ifdef GATE_VECTOR_STEPPER_FAILVEC_EN
    fv_exp = 2'b11;
`else
    fv_exp = 2'b00;
`endif
    mode = 1;
    run(0, dn, stb, vs);
    check("t0_done_t", dn, 17); check("t0_err", err_cnt, 1); check("t0_pass", pass, 0);
    check("t0_fail", fail_vec, fv_exp);
    mode = 2;
    run(0, dn, stb, vs);
    check("t1_err", err_cnt, 3); check("t1_pass", pass, 0); check("t1_fail", fail_vec, 0);
    mode = 0;
    run(6, dn, stb, vs);
    check("restart_done_t", dn, 17); check("restart_stb", stb, 4); check("restart_pass", pass, 1);
    @(posedge clk) #1 check("done_pulse_len", done, 0);
    mode = 2;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("pre_rst_vec", vec, 2);
    check("pre_rst_err", err_cnt, 2);
    rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    check("abort_vec", vec, 0); check("abort_busy", busy, 0); check("abort_err", err_cnt, 0);
    dn = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk) #1;
      dn += int'(done);
    end
    check("abort_no_done", dn, 0);
    dn = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    for (int n = 1; n <= 20 && dn == 0; n++) begin
      @(posedge clk) #1;
      if (done2) dn = n;
    end
    check("or_done_t", dn, 5); check("or_pass", pass2, 1); check("or_err", err_cnt2, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
